// File: rtl/gaus_window_shifter.sv
// Five-row window source: four chained line delays feed five 5-pixel shift rows,
// with frame position tracking to flag complete in-frame 5x5 windows.

module gaus_line_delay #(
  parameter int IMGW    = 384,
  parameter int PIXBITS = 8,
  parameter int AW      = 9
) (
  input  logic               clk,
  input  logic               en,
  input  logic [AW-1:0]      ptr,
  input  logic [PIXBITS-1:0] din,
  output logic [PIXBITS-1:0] dout
);
  logic [PIXBITS-1:0] mem [IMGW];

  // Read-before-write at the shared pointer gives exactly IMGW beats of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk)
    if (en) mem[ptr] <= din;
endmodule

module gaus_window_shifter #(
  parameter int IMGW    = 384,
  parameter int PIXBITS = 8,
  parameter int PIXW    = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIXBITS-1:0]   PixIn,
  input  logic                 PixValid,
  input  logic                 SoF,
  output logic [5*PIXBITS-1:0] ShiftA,
  output logic [5*PIXBITS-1:0] ShiftB,
  output logic [5*PIXBITS-1:0] ShiftC,
  output logic [5*PIXBITS-1:0] ShiftD,
  output logic [5*PIXBITS-1:0] ShiftE,
  output logic                 WinValid,
  output logic [PIXW-1:0]      PixCount
);
  localparam int AW = $clog2(IMGW);
  localparam int RW = 5 * PIXBITS;
  localparam logic [AW-1:0] LAST = AW'(IMGW - 1);

  logic                          accept;
  logic [AW-1:0]                 ptr;
  logic [4:0][PIXBITS-1:0]       rowIn;   // [0] = current line ... [4] = oldest line
  logic [4:0][RW-1:0]            shiftR;
  logic [AW-1:0]                 col, effCol;
  logic [2:0]                    row, effRow;

  // A beat coinciding with reset is dropped everywhere, including the line delays.
  assign accept   = PixValid & ~reset;
  assign rowIn[0] = PixIn;

  for (genvar k = 0; k < 4; k++) begin : gLd
    gaus_line_delay #(.IMGW(IMGW), .PIXBITS(PIXBITS), .AW(AW)) uLd (
      .clk  (clk),
      .en   (accept),
      .ptr  (ptr),
      .din  (rowIn[k]),
      .dout (rowIn[k+1])
    );
  end

  // SoF pins the accepted pixel to the frame origin.
  assign effCol = SoF ? '0 : col;
  assign effRow = SoF ? '0 : row;

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftR   <= '0;
      WinValid <= 1'b0;
      PixCount <= '0;
      col      <= '0;
      row      <= '0;
      ptr      <= '0;
    end else begin
      WinValid <= 1'b0;
      if (PixValid) begin
        for (int r = 0; r < 5; r++)
          shiftR[r] <= {shiftR[r][RW-PIXBITS-1:0], rowIn[r]};
        WinValid <= (effRow == 3'd4) && (effCol >= AW'(4));
        ptr      <= (ptr == LAST) ? '0 : ptr + AW'(1);
        if (effCol == LAST) begin
          col <= '0;
          row <= (effRow == 3'd4) ? 3'd4 : effRow + 3'd1;
        end else begin
          col <= effCol + AW'(1);
          row <= effRow;
        end
        if (SoF)           PixCount <= PIXW'(1);
        else if (~&PixCount) PixCount <= PixCount + PIXW'(1);
      end
    end
  end

  assign ShiftE = shiftR[0];
  assign ShiftD = shiftR[1];
  assign ShiftC = shiftR[2];
  assign ShiftB = shiftR[3];
  assign ShiftA = shiftR[4];
endmodule

// File: tb/tb_gaus_window_shifter.sv
// Scoreboard bench: model derives every output from the accepted-pixel history.

module tb_gaus_window_shifter;
  localparam int IMGW = 8;
  localparam int PIXW = 6;
  localparam int PCMAX = (1 << PIXW) - 1;

  logic        clk = 0;
  logic        reset = 1;
  logic [7:0]  PixIn = 0;
  logic        PixValid = 0;
  logic        SoF = 0;
  logic [39:0] ShiftA, ShiftB, ShiftC, ShiftD, ShiftE;
  logic        WinValid;
  logic [PIXW-1:0] PixCount;

  gaus_window_shifter #(.IMGW(IMGW), .PIXBITS(8), .PIXW(PIXW)) dut (
    .clk(clk), .reset(reset), .PixIn(PixIn), .PixValid(PixValid), .SoF(SoF),
    .ShiftA(ShiftA), .ShiftB(ShiftB), .ShiftC(ShiftC), .ShiftD(ShiftD), .ShiftE(ShiftE),
    .WinValid(WinValid), .PixCount(PixCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][39:0] sh;   // [0]=E .. [4]=A
    logic [4:0]       kn;   // row fully determined by the model
    logic             win;
    logic [PIXW-1:0]  pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: every pixel ever accepted, where the last reset fell, frame position.
  logic [7:0] hist[$];
  int resetIdx = 0;
  int frameN = 0;
  int mPc = 0;

  task automatic step(input bit v, input bit s, input logic [7:0] p, input bit r);
    exp_t e;
    int h, j, src;
    @(negedge clk);
    PixValid = v; SoF = s; PixIn = p; reset = r;
    @(posedge clk);
    e = '0;
    if (r) begin
      resetIdx = hist.size();
      frameN = 0;
      mPc = 0;
    end else if (v) begin
      if (s) begin
        frameN = 0;
        mPc = 1;
      end else begin
        mPc = (mPc == PCMAX) ? PCMAX : mPc + 1;
      end
      e.win = (frameN / IMGW >= 4) && (frameN % IMGW >= 4);
      hist.push_back(p);
      frameN++;
    end
    e.pc = PIXW'(mPc);
    h = hist.size() - 1;
    // Row d shows the pixel stream delayed by d lines; slots before the reset read zero,
    // delayed pixels from before the reset are stale storage and left unchecked.
    for (int d = 0; d < 5; d++) begin
      e.kn[d] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        j = h - k;
        if (j >= resetIdx) begin
          src = j - IMGW * d;
          if (src < resetIdx) e.kn[d] = 1'b0;
          else e.sh[d][8*k +: 8] = hist[src];
        end
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0][39:0] act;
    string nm [5];
    nm[0] = "ShiftE"; nm[1] = "ShiftD"; nm[2] = "ShiftC"; nm[3] = "ShiftB"; nm[4] = "ShiftA";
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act[0] = ShiftE; act[1] = ShiftD; act[2] = ShiftC; act[3] = ShiftB; act[4] = ShiftA;
        checks++;
        if (WinValid !== e.win) begin
          errors++;
          $display("FAIL WinValid t=%0t got %b expected %b", $time, WinValid, e.win);
        end
        checks++;
        if (PixCount !== e.pc) begin
          errors++;
          $display("FAIL PixCount t=%0t got %0d expected %0d", $time, PixCount, e.pc);
        end
        for (int d = 0; d < 5; d++) begin
          if (e.kn[d]) begin
            checks++;
            if (act[d] !== e.sh[d]) begin
              errors++;
              $display("FAIL %s t=%0t got %h expected %h", nm[d], $time, act[d], e.sh[d]);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset held with PixValid high: beats dropped, outputs zero.
    step(1, 1, 8'hAA, 1);
    step(1, 0, 8'h55, 1);
    // Window fill with a 3-cycle gap after index 20, running into row 5.
    for (int i = 0; i < 50; i++) begin
      step(1, i == 0, 8'(i), 0);
      if (i == 20) repeat (3) step(0, 0, 8'hEE, 0);
    end
    // Mid-frame SoF at index 50.
    for (int i = 50; i < 100; i++) step(1, i == 50, 8'(i), 0);
    // Restart stream, reset at index 40, then refill from reset without SoF.
    for (int i = 0; i < 40; i++) step(1, i == 0, 8'(i), 0);
    step(1, 0, 8'd40, 1);
    for (int i = 0; i < 46; i++) step(1, 0, 8'(i), 0);
    // Random traffic: gaps, stray SoF (also while idle), rare resets, long frames.
    for (int i = 0; i < 900; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 119) == 0,
           8'($urandom), $urandom_range(0, 399) == 0);
    step(0, 0, 8'h00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
